logic_issue_stage: RTL and testbench
====================================

# logic_issue_stage

Pipeline stage directly upstream of the logic unit. Accepts decoded register/immediate logic micro-ops over a valid/ready handshake and maps RV32I funct3 to the logic-unit operation code. Selects and forwards operands, then presents registered `a`, `b` and `operation` to the logic unit. A two-entry skid buffer gives full throughput and a registered `in_ready`.

## Interface
- `DATA_WIDTH`, 32, operand width.
- `REG_IDX_W`, 5, register index width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: **synchronous, active-high reset.**
- `in_valid` in 1: upstream micro-op valid.
- `in_ready` out 1: stage can accept.
- `in_funct3` in 3: RV32I funct3.
- `in_rs1_idx`, `in_rs2_idx` in REG_IDX_W: source register indices.
- `in_rs1_val`, `in_rs2_val` in DATA_WIDTH: register-file read data.
- `in_imm` in DATA_WIDTH: sign-extended immediate.
- `in_use_imm` in 1: operand b is the immediate, not rs2.
- `in_rd` in REG_IDX_W: destination index, passed through.
- `wb_valid` in 1: writeback bus valid, used for forwarding.
- `wb_rd` in REG_IDX_W: writeback destination index.
- `wb_data` in DATA_WIDTH: writeback data.
- `out_valid` out 1: `a`/`b`/`operation`/`out_rd` valid.
- `out_ready` in 1: downstream accepts.
- `a`, `b` out DATA_WIDTH: operands to the logic unit.
- `operation` out 3: logic-unit op code.
- `out_rd` out REG_IDX_W: destination index.
- `illegal_op` out 1: one-cycle pulse on an accepted unsupported funct3.

## Operation
- Accept occurs when `in_valid && in_ready`.
- funct3 mapping:
  - 3'b111 → OP_AND (3'b000).
  - 3'b110 → OP_OR (3'b001).
  - 3'b100 → OP_XOR (3'b010).
  - Any other funct3 is accepted and consumed but not enqueued. `illegal_op` is 1 on the following cycle.
- Operand select, evaluated at accept only:
  - Index 0 → operand is 0, regardless of forwarding.
  - Else if `wb_valid && wb_rd == idx` → operand is `wb_data`.
  - Else → operand is the register-file value.
  - `b` is `in_imm` when `in_use_imm` is set; no forwarding is applied to the immediate.
- Buffered entries are not re-forwarded. Later hazards belong to upstream interlock.
- Storage:
  - Output register (OUT) plus one skid register (SKID), each holding a, b, operation, rd and a valid bit.
  - Accept with OUT empty, or OUT draining this cycle with SKID empty → write OUT.
  - Accept with OUT full and not draining → write SKID.
  - OUT drains while SKID is full → SKID moves to OUT in the same cycle; a simultaneous accept is impossible because `in_ready` is 0.
- Occupancy states: EMPTY, ONE (OUT only), FULL (OUT + SKID).
  - EMPTY→ONE on accept.
  - ONE→ONE on accept and drain together.
  - ONE→FULL on accept without drain.
  - ONE→EMPTY on drain without accept.
  - FULL→ONE on drain.
- `in_ready = !skid_valid && !rst`.
- Reset mid-operation discards all entries, and no `illegal_op` pulse follows.

## Timing
- Reset values:
  - `out_valid`=0, `a`=0, `b`=0, `operation`=0, `out_rd`=0, `illegal_op`=0.
  - Skid register empty.
  - `in_ready`=0 while `rst` is high and 1 on the first cycle after it deasserts.
- Latency is one cycle: an accept at edge N gives `out_valid`=1 after edge N.
- Throughput is one op per cycle with `out_ready` held high.
- `a`, `b`, `operation` and `out_rd` are stable while `out_valid && !out_ready`.
- `in_ready` depends only on registered state, never on `out_ready` in the same cycle.
- `illegal_op` is registered, with one cycle latency from accept.

## Structure
- Package `logic_pkg`:
  - `logic_op_e` enum (OP_AND=3'b000, OP_OR=3'b001, OP_XOR=3'b010), shared with the logic unit.
  - funct3 constants FUNCT3_AND/OR/XOR.
  - `issue_entry_t` struct {a, b, op, rd}.
- Sub-module `operand_fwd`: combinational operand select (x0, writeback match, register file), instantiated once per source operand.
- The skid buffer stays inline.

## Test plan
- Reset, then accept funct3=111, rs1 val 0xF0F0_F0F0, rs2 val 0x0FF0_0FF0 → next cycle `out_valid`=1, `operation`=000, `a`=0xF0F0_F0F0, `b`=0x0FF0_0FF0.
- Accept with rs1_idx=3, `wb_valid`=1, `wb_rd`=3, `wb_data`=0x1234_5678, `in_use_imm`=1, imm=0xFFFF_FFFF, funct3=100 → `a`=0x1234_5678, `b`=0xFFFF_FFFF, `operation`=010.
- rs2_idx=0 with rs2 val 0xDEAD_BEEF, `wb_valid`=1 and `wb_rd`=0 → `b`=0.
- Hold `out_ready`=0 and push 3 ops → first two accepted, `in_ready`=0 on the third. Release `out_ready` → ops drain in order on consecutive cycles with no loss or duplication.
- Accept funct3=001 → `illegal_op` pulses exactly one cycle, `out_valid` stays 0.
- Assert `rst` while FULL → on the next cycle `out_valid`=0, `in_ready`=0 until `rst` falls, and no stale op appears afterwards.

Source files
------------

// File: rtl/logic_issue_stage_pkg.sv
// Shared types for the logic issue stage and the logic unit it feeds.
package logic_pkg;
    localparam int LOGIC_DATA_W = 32;
    localparam int LOGIC_IDX_W  = 5;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010
    } logic_op_e;

    localparam logic [2:0] FUNCT3_AND = 3'b111;
    localparam logic [2:0] FUNCT3_OR  = 3'b110;
    localparam logic [2:0] FUNCT3_XOR = 3'b100;

    typedef struct packed {
        logic [LOGIC_DATA_W-1:0] a;
        logic [LOGIC_DATA_W-1:0] b;
        logic_op_e               op;
        logic [LOGIC_IDX_W-1:0]  rd;
    } issue_entry_t;

    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 == FUNCT3_AND) || (f3 == FUNCT3_OR) || (f3 == FUNCT3_XOR);
    endfunction

    function automatic logic_op_e funct3_to_op(input logic [2:0] f3);
        case (f3)
            FUNCT3_OR:  return OP_OR;
            FUNCT3_XOR: return OP_XOR;
            default:    return OP_AND;
        endcase
    endfunction
endpackage

// File: rtl/logic_issue_stage_if.sv
// Micro-op in, writeback snoop, and logic-unit out for the issue stage.
interface logic_issue_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_IDX_W  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_funct3;
    logic [REG_IDX_W-1:0]  in_rs1_idx;
    logic [REG_IDX_W-1:0]  in_rs2_idx;
    logic [DATA_WIDTH-1:0] in_rs1_val;
    logic [DATA_WIDTH-1:0] in_rs2_val;
    logic [DATA_WIDTH-1:0] in_imm;
    logic                  in_use_imm;
    logic [REG_IDX_W-1:0]  in_rd;
    logic                  wb_valid;
    logic [REG_IDX_W-1:0]  wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [2:0]            operation;
    logic [REG_IDX_W-1:0]  out_rd;
    logic                  illegal_op;

    modport slave (
        input  in_valid, in_funct3, in_rs1_idx, in_rs2_idx, in_rs1_val, in_rs2_val,
               in_imm, in_use_imm, in_rd, wb_valid, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, a, b, operation, out_rd, illegal_op
    );

    modport master (
        output in_valid, in_funct3, in_rs1_idx, in_rs2_idx, in_rs1_val, in_rs2_val,
               in_imm, in_use_imm, in_rd, wb_valid, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, a, b, operation, out_rd, illegal_op
    );
endinterface

// File: rtl/logic_issue_stage_operand_fwd.sv
// Source operand select: x0 reads zero, then writeback bypass, then register file.
module operand_fwd #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_IDX_W  = 5
) (
    input  logic [REG_IDX_W-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] rf_val,
    input  logic                  wb_valid,
    input  logic [REG_IDX_W-1:0]  wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] operand
);
    always_comb begin
        if (idx == '0)
            operand = '0;
        else if (wb_valid && wb_rd == idx)
            operand = wb_data;
        else
            operand = rf_val;
    end
endmodule

// File: rtl/logic_issue_stage.sv
// Issue stage ahead of the logic unit: funct3 decode, operand select, 2-entry skid buffer.
module logic_issue_stage
    import logic_pkg::*;
#(
    parameter int DATA_WIDTH = LOGIC_DATA_W,
    parameter int REG_IDX_W  = LOGIC_IDX_W
) (
    input logic                clk,
    input logic                rst,
    logic_issue_stage_if.slave bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} occ_e;

    occ_e         state, state_nxt;
    issue_entry_t out_q, skid_q, in_entry;
    logic         illegal_q;
    logic         accept, legal, push, drain;
    logic         load_out, load_skid, out_from_skid;
    logic [DATA_WIDTH-1:0] rs1_op, rs2_op;

    operand_fwd #(.DATA_WIDTH(DATA_WIDTH), .REG_IDX_W(REG_IDX_W)) u_fwd_rs1 (
        .idx(bus.in_rs1_idx), .rf_val(bus.in_rs1_val), .wb_valid(bus.wb_valid),
        .wb_rd(bus.wb_rd), .wb_data(bus.wb_data), .operand(rs1_op)
    );

    operand_fwd #(.DATA_WIDTH(DATA_WIDTH), .REG_IDX_W(REG_IDX_W)) u_fwd_rs2 (
        .idx(bus.in_rs2_idx), .rf_val(bus.in_rs2_val), .wb_valid(bus.wb_valid),
        .wb_rd(bus.wb_rd), .wb_data(bus.wb_data), .operand(rs2_op)
    );

    assign bus.in_ready = (state != S_FULL) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign legal        = funct3_legal(bus.in_funct3);
    assign push         = accept && legal;
    assign drain        = (state != S_EMPTY) && bus.out_ready;

    always_comb begin
        in_entry.a  = rs1_op;
        in_entry.b  = bus.in_use_imm ? bus.in_imm : rs2_op;
        in_entry.op = funct3_to_op(bus.in_funct3);
        in_entry.rd = bus.in_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_nxt;
    end

    // FULL never sees a push: in_ready is low there, so only the drain path matters.
    always_comb begin
        state_nxt     = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            S_EMPTY: if (push) begin
                state_nxt = S_ONE;
                load_out  = 1'b1;
            end
            S_ONE: begin
                if (push && drain) begin
                    load_out = 1'b1;
                end else if (push) begin
                    state_nxt = S_FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: if (drain) begin
                state_nxt     = S_ONE;
                out_from_skid = 1'b1;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            skid_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (load_out)           out_q  <= in_entry;
            else if (out_from_skid) out_q  <= skid_q;
            if (load_skid)          skid_q <= in_entry;
            illegal_q <= accept && !legal;
        end
    end

    assign bus.out_valid  = (state != S_EMPTY);
    assign bus.a          = out_q.a;
    assign bus.b          = out_q.b;
    assign bus.operation  = out_q.op;
    assign bus.out_rd     = out_q.rd;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_logic_issue_stage.sv
// Bench for logic_issue_stage: directed scenarios plus random traffic against a queue model.
module tb_logic_issue_stage;
    import logic_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic_issue_stage_if bus ();

    logic_issue_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    logic exp_ill;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'h0;
        if (bus.wb_valid && bus.wb_rd == idx) return bus.wb_data;
        return rf;
    endfunction

    task automatic drive(input logic v, input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic ui, input logic [4:0] rd);
        bus.in_valid = v;   bus.in_funct3 = f3;
        bus.in_rs1_idx = r1; bus.in_rs2_idx = r2;
        bus.in_rs1_val = v1; bus.in_rs2_val = v2;
        bus.in_imm = imm;   bus.in_use_imm = ui; bus.in_rd = rd;
    endtask

    // Advance one clock while updating the model from the pre-edge inputs.
    task automatic step();
        exp_t e;
        logic acc, drn, lg;
        acc = bus.in_valid && !rst && (q.size() < 2);
        drn = (q.size() > 0) && bus.out_ready;
        lg  = (bus.in_funct3 == 3'b111) || (bus.in_funct3 == 3'b110) || (bus.in_funct3 == 3'b100);
        e.a  = src_val(bus.in_rs1_idx, bus.in_rs1_val);
        e.b  = bus.in_use_imm ? bus.in_imm : src_val(bus.in_rs2_idx, bus.in_rs2_val);
        e.op = (bus.in_funct3 == 3'b110) ? 3'b001 : (bus.in_funct3 == 3'b100) ? 3'b010 : 3'b000;
        e.rd = bus.in_rd;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_ill = 1'b0;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc && lg) q.push_back(e);
            exp_ill = acc && !lg;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        drive(1'b0, 3'b0, '0, '0, '0, '0, '0, 1'b0, '0);
        repeat (3) step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if ({bus.a, bus.b, bus.operation, bus.out_rd, bus.illegal_op} !== '0) begin
            failures++; $display("FAIL reset_outputs a=%h b=%h op=%b rd=%0d ill=%b exp=all zero",
                                 bus.a, bus.b, bus.operation, bus.out_rd, bus.illegal_op);
        end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b111, 5'd1, 5'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1'b0, 5'd7);
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.operation !== 3'b000 || bus.a !== 32'hF0F0_F0F0 ||
                      bus.b !== 32'h0FF0_0FF0 || bus.out_rd !== 5'd7) begin
            failures++; $display("FAIL basic_and v=%b op=%b a=%h b=%h rd=%0d exp 1/000/f0f0f0f0/0ff00ff0/7",
                                 bus.out_valid, bus.operation, bus.a, bus.b, bus.out_rd);
        end
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h1234_5678;
        drive(1'b1, 3'b100, 5'd3, 5'd4, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b1, 5'd9);
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.operation !== 3'b010 || bus.a !== 32'h1234_5678 ||
                      bus.b !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL fwd_imm v=%b op=%b a=%h b=%h exp 1/010/12345678/ffffffff",
                                 bus.out_valid, bus.operation, bus.a, bus.b);
        end
        bus.wb_rd = 5'd0; bus.wb_data = 32'hCAFE_CAFE;
        drive(1'b1, 3'b110, 5'd5, 5'd0, 32'h0000_1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd2);
        step();
        checks++; if (bus.operation !== 3'b001 || bus.b !== 32'h0 || bus.a !== 32'h0000_1111) begin
            failures++; $display("FAIL x0_operand op=%b a=%h b=%h exp 001/00001111/0", bus.operation, bus.a, bus.b);
        end
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 3'b111, 5'(i), 5'd0, 32'(i * 32'h11), 32'h0, 32'h0, 1'b0, 5'(i));
            if (i < 3) step();
        end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.a !== 32'h11 || bus.out_rd !== 5'd1) begin
            failures++; $display("FAIL bp_hold v=%b a=%h rd=%0d exp 1/11/1", bus.out_valid, bus.a, bus.out_rd);
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.a !== 32'h22 || bus.out_rd !== 5'd2 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_second v=%b a=%h rd=%0d rdy=%b exp 1/22/2/1",
                                 bus.out_valid, bus.a, bus.out_rd, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.a !== 32'h33 || bus.out_rd !== 5'd3) begin
            failures++; $display("FAIL bp_third v=%b a=%h rd=%0d exp 1/33/3", bus.out_valid, bus.a, bus.out_rd);
        end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b001, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 5'd4);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.illegal_op !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL illegal_pulse ill=%b v=%b exp 1/0", bus.illegal_op, bus.out_valid);
        end
        step();
        checks++; if (bus.illegal_op !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL illegal_one_cycle ill=%b v=%b exp 0/0", bus.illegal_op, bus.out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'b110, 5'd6, 5'd7, 32'hBAD0_0000 + 32'(i), 32'h1, 32'h0, 1'b0, 5'd8);
            step();
        end
        rst = 1'b1;
        bus.in_funct3 = 3'b011;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.illegal_op !== 1'b0) begin
            failures++; $display("FAIL rst_mid v=%b rdy=%b ill=%b exp 0/0/0", bus.out_valid, bus.in_ready, bus.illegal_op);
        end
        step();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_hold_in_ready got=%b exp=0", bus.in_ready); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) begin
            step();
            checks++; if (bus.out_valid !== 1'b0 || bus.illegal_op !== 1'b0) begin
                failures++; $display("FAIL rst_no_stale v=%b ill=%b exp 0/0", bus.out_valid, bus.illegal_op);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] prev_a, prev_b;
        logic        prev_hold;
        prev_hold = 1'b0; prev_a = '0; prev_b = '0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.wb_valid = $urandom_range(0, 1);
            bus.wb_rd = 5'($urandom_range(0, 7));
            bus.wb_data = $urandom;
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)));
            #1;
            checks++; if (bus.in_ready !== (!rst && q.size() < 2)) begin
                failures++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, bus.in_ready, !rst && q.size() < 2);
            end
            prev_hold = bus.out_valid && !bus.out_ready && !rst;
            prev_a = bus.a; prev_b = bus.b;
            step();
            checks++; if (bus.out_valid !== (q.size() > 0)) begin
                failures++; $display("FAIL rnd_out_valid n=%0d got=%b exp=%b", n, bus.out_valid, q.size() > 0);
            end
            checks++; if (bus.illegal_op !== exp_ill) begin
                failures++; $display("FAIL rnd_illegal n=%0d got=%b exp=%b", n, bus.illegal_op, exp_ill);
            end
            if (q.size() > 0) begin
                checks++; if (bus.a !== q[0].a || bus.b !== q[0].b || bus.operation !== q[0].op || bus.out_rd !== q[0].rd) begin
                    failures++; $display("FAIL rnd_entry n=%0d got a=%h b=%h op=%b rd=%0d exp a=%h b=%h op=%b rd=%0d",
                                         n, bus.a, bus.b, bus.operation, bus.out_rd, q[0].a, q[0].b, q[0].op, q[0].rd);
                end
            end
            if (prev_hold) begin
                checks++; if (bus.a !== prev_a || bus.b !== prev_b) begin
                    failures++; $display("FAIL rnd_stable n=%0d a=%h b=%h exp a=%h b=%h", n, bus.a, bus.b, prev_a, prev_b);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        exp_ill = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
